mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 25 ++
 rtl/mult_div_unit.sv | 126 ++++++++++++
 tb/tb_mult_div_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide select encodings and latencies.
// The E-stage control decoder drives mult_div_sel_E with these values, and the
// multiply/divide unit decodes the same values, so both sides agree on them.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    NO_START    = 4'd0,
    START_MULT  = 4'd1,
    START_MULTU = 4'd2,
    START_DIV   = 4'd3,
    START_DIVU  = 4'd4,
    START_MTHI  = 4'd5,
    START_MTLO  = 4'd6
  } mult_div_sel_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  // True for the four encodings that launch a multi-cycle operation.
  function automatic logic is_start_op(input logic [3:0] sel);
    return (sel == START_MULT) || (sel == START_MULTU) ||
           (sel == START_DIV)  || (sel == START_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// The full 64-bit result is computed combinationally from A/B at the accept
// edge and parked in pending registers. A countdown models the pipeline
// latency, and HI/LO are written only when the countdown expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mult_div_sel_E,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [3:0]  counter;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_write;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] den_s;
  logic [31:0] den_u;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_write;
  logic        is_mult;

  assign Start = is_start_op(mult_div_sel_E);
  assign Busy  = (counter != 4'd0);

  // Result for the operation currently selected. Signed division works on
  // magnitudes and then fixes the signs, which also gives 0x80000000 / -1 ->
  // quotient 0x80000000, remainder 0. A zero divisor is swapped for 1 so the
  // divider never sees zero, and the result is flagged as not to be written.
  always_comb begin
    prod_s    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u    = {32'd0, A} * {32'd0, B};
    a_neg     = A[31];
    b_neg     = B[31];
    a_mag     = a_neg ? (~A + 32'd1) : A;
    b_mag     = b_neg ? (~B + 32'd1) : B;
    den_s     = (B == 32'd0) ? 32'd1 : b_mag;
    den_u     = (B == 32'd0) ? 32'd1 : B;
    q_mag     = a_mag / den_s;
    r_mag     = a_mag % den_s;
    q_s       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    r_s       = a_neg ? (~r_mag + 32'd1) : r_mag;
    q_u       = A / den_u;
    r_u       = A % den_u;
    res_hi    = 32'd0;
    res_lo    = 32'd0;
    res_write = 1'b0;
    is_mult   = 1'b0;
    case (mult_div_sel_E)
      START_MULT: begin
        res_hi    = prod_s[63:32];
        res_lo    = prod_s[31:0];
        res_write = 1'b1;
        is_mult   = 1'b1;
      end
      START_MULTU: begin
        res_hi    = prod_u[63:32];
        res_lo    = prod_u[31:0];
        res_write = 1'b1;
        is_mult   = 1'b1;
      end
      START_DIV: begin
        res_hi    = r_s;
        res_lo    = q_s;
        res_write = (B != 32'd0);
      end
      START_DIVU: begin
        res_hi    = r_u;
        res_lo    = q_u;
        res_write = (B != 32'd0);
      end
      default: begin
        res_write = 1'b0;
      end
    endcase
  end

  // Reset first, then countdown/completion while busy, otherwise accept a
  // new operation or a direct HI/LO move. Nothing is accepted while busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter    <= 4'd0;
      HI         <= 32'd0;
      LO         <= 32'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_write <= 1'b0;
    end else if (counter != 4'd0) begin
      counter <= counter - 4'd1;
      if ((counter == 4'd1) && pend_write) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else if (Start) begin
      counter    <= is_mult ? MULT_CYCLES : DIV_CYCLES;
      pend_hi    <= res_hi;
      pend_lo    <= res_lo;
      pend_write <= res_write;
    end else if (mult_div_sel_E == START_MTHI) begin
      HI <= A;
    end else if (mult_div_sel_E == START_MTLO) begin
      LO <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a transaction-level reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  mult_div_sel_E = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mult_div_unit dut (
    .clk(clk),
    .reset(reset),
    .mult_div_sel_E(mult_div_sel_E),
    .A(A),
    .B(B),
    .Start(Start),
    .Busy(Busy),
    .HI(HI),
    .LO(LO)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One comparison; reports a FAIL line on a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: HI/LO state, whether an op is in flight, and the
  // absolute edge number at which its result lands.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          m_busy = 1'b0;
  bit          m_write = 1'b0;
  logic [31:0] m_res_hi = 32'd0;
  logic [31:0] m_res_lo = 32'd0;
  int          m_edge = 0;
  int          m_done = 0;

  // Architectural result of an op, straight from the arithmetic definitions.
  task automatic modelResult(input logic [3:0] sel, input logic [31:0] a,
                             input logic [31:0] b, output logic [31:0] hi,
                             output logic [31:0] lo, output bit wr);
    int          sa;
    int          sb;
    longint      ps;
    logic [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    hi = 32'd0;
    lo = 32'd0;
    wr = 1'b1;
    if (sel == 4'd1) begin
      ps = longint'(sa) * longint'(sb);
      hi = ps[63:32];
      lo = ps[31:0];
    end else if (sel == 4'd2) begin
      pu = {32'd0, a} * {32'd0, b};
      hi = pu[63:32];
      lo = pu[31:0];
    end else if (b == 32'd0) begin
      wr = 1'b0;
    end else if (sel == 4'd3) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000;
        hi = 32'd0;
      end else begin
        lo = sa / sb;
        hi = sa % sb;
      end
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // Model update at every rising edge from the inputs the DUT also sees.
  always @(posedge clk) begin
    m_edge++;
    if (!reset) begin
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_edge == m_done) begin
        if (m_write) begin
          m_hi = m_res_hi;
          m_lo = m_res_lo;
        end
        m_busy = 1'b0;
      end
    end else if (mult_div_sel_E >= 4'd1 && mult_div_sel_E <= 4'd4) begin
      modelResult(mult_div_sel_E, A, B, m_res_hi, m_res_lo, m_write);
      m_busy = 1'b1;
      m_done = m_edge + ((mult_div_sel_E <= 4'd2) ? 5 : 10);
    end else if (mult_div_sel_E == 4'd5) begin
      m_hi = A;
    end else if (mult_div_sel_E == 4'd6) begin
      m_lo = A;
    end
  end

  // Every-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_busy", {31'd0, Busy}, {31'd0, m_busy});
      checkOutput("model_hi", HI, m_hi);
      checkOutput("model_lo", LO, m_lo);
      checkOutput("model_start", {31'd0, Start},
                  {31'd0, (mult_div_sel_E >= 4'd1 && mult_div_sel_E <= 4'd4)});
    end
  end

  // Present one op for exactly one rising edge, then scramble A/B.
  task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] a,
                               input logic [31:0] b);
    @(posedge clk);
    #2;
    mult_div_sel_E = sel;
    A = a;
    B = b;
    @(posedge clk);
    #2;
    mult_div_sel_E = 4'd0;
    A = $urandom;
    B = $urandom;
  endtask

  // Count Busy-high falling edges until Busy drops; bounded.
  task automatic waitIdle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!Busy) return;
      n++;
    end
    checkOutput("busy_timeout", 32'd1, 32'd0);
  endtask

  // Full op with busy-length and result checks against literals.
  task automatic runOp(input string name, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input int cycles, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int n;
    applyStimulus(sel, a, b);
    waitIdle(n);
    checkOutput({name, "_busy_cycles"}, n, cycles);
    checkOutput({name, "_hi"}, HI, exp_hi);
    checkOutput({name, "_lo"}, LO, exp_lo);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int m;
    repeat (3) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_hi", HI, 32'd0);
    checkOutput("reset_lo", LO, 32'd0);
    checkOutput("reset_busy", {31'd0, Busy}, 32'd0);

    runOp("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    runOp("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div_negb", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    runOp("divu", 4'd4, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E);
    runOp("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

    // Direct moves, then divide by zero leaves HI/LO alone.
    applyStimulus(4'd5, 32'hFFFF_FFFF, 32'd0);
    applyStimulus(4'd6, 32'h0000_1234, 32'd0);
    @(negedge clk);
    checkOutput("mtlo_lo", LO, 32'h0000_1234);
    runOp("divu_zero", 4'd4, 32'h5555_5555, 32'd0, 10, 32'hFFFF_FFFF, 32'h0000_1234);

    // mthi and a second start while busy are ignored.
    applyStimulus(4'd1, 32'h0001_0000, 32'h0001_0000);
    mult_div_sel_E = 4'd5;
    A = 32'hAAAA_0000;
    n = 0;
    @(negedge clk);
    if (Busy) n++;
    @(posedge clk);
    #2;
    mult_div_sel_E = 4'd3;
    A = 32'd9;
    B = 32'd3;
    @(posedge clk);
    #2;
    mult_div_sel_E = 4'd0;
    waitIdle(m);
    n = n + m + 1;
    checkOutput("mthi_busy_cycles", n, 5);
    checkOutput("mthi_busy_hi", HI, 32'h0000_0001);
    checkOutput("mthi_busy_lo", LO, 32'h0000_0000);

    // Reset during busy cycle 3 of a divide, with a mult presented alongside.
    applyStimulus(4'd3, 32'd100, 32'd3);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset = 1'b0;
    mult_div_sel_E = 4'd1;
    A = 32'd5;
    B = 32'd6;
    @(posedge clk);
    #2;
    reset = 1'b1;
    mult_div_sel_E = 4'd0;
    @(negedge clk);
    checkOutput("rst_mid_busy", {31'd0, Busy}, 32'd0);
    checkOutput("rst_mid_hi", HI, 32'd0);
    checkOutput("rst_mid_lo", LO, 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("rst_late_hi", HI, 32'd0);
    checkOutput("rst_late_lo", LO, 32'd0);
    checkOutput("rst_late_busy", {31'd0, Busy}, 32'd0);

    // Start decode for every encoding, held in reset so nothing is accepted.
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mult_div_sel_E = i[3:0];
      A = 32'hDEAD_BEEF;
      #1;
      checkOutput($sformatf("start_sel%0d", i), {31'd0, Start},
                  {31'd0, (i >= 1 && i <= 4)});
      @(posedge clk);
      #2;
    end
    mult_div_sel_E = 4'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
